fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side master for the sync FIFO: drains it through the FIFO's rd_en/rdata/empty interface.
//   Re-presents the words as a valid/ready stream with packet framing (m_last).
//   Hides the FIFO's 1-cycle read latency behind a small output buffer.
//   Sustains 1 word/clk with no combinational path from m_ready to fifo_rd_en.
// PARAMETERS
//   DATA_WIDTH  8  word width; matches the FIFO DATA_WIDTH
//   BUF_DEPTH   3  output buffer entries; legal >=2; 3 required for full throughput
//   PKT_LEN     4  beats per packet; m_last marks beat PKT_LEN-1; legal >=1
// PORTS
//   clk         in   1           clock, rising edge
//   rst         in   1           asynchronous reset, active-low
//   fifo_empty  in   1           FIFO empty flag
//   fifo_rd_en  out  1           FIFO pop request
//   fifo_rdata  in   DATA_WIDTH  FIFO read data, valid the cycle after a pop
//   m_valid     out  1           output word valid
//   m_ready     in   1           downstream accepts word
//   m_data      out  DATA_WIDTH  output word
//   m_last      out  1           last beat of packet
//   busy        out  1           buffer non-empty or read in flight
// BEHAVIOUR
//   Reset (rst=0, async): state values
//     - occ=0, inflight=0, beat=0
//     - m_valid=0, m_data=0, m_last=0, busy=0
//     - fifo_rd_en forced 0 while rst=0
//   Internal state
//     - occ: buffer occupancy, width $clog2(BUF_DEPTH+1)
//     - inflight: 1-bit register, equals last cycle's fifo_rd_en
//     - circular buffer with head/tail pointers that wrap at BUF_DEPTH
//   Issue rule (combinational from registered state and fifo_empty only)
//     - fifo_rd_en = !fifo_empty && (occ + inflight < BUF_DEPTH)
//     - Every issued rd_en is a real pop; never assert rd_en while fifo_empty=1.
//   Capture
//     - If inflight=1, write fifo_rdata into the tail entry on this edge.
//     - Latency: rd_en at edge N -> word in buffer after edge N+1.
//     - m_valid rises the cycle after capture.
//     - First word: fifo_empty falls -> m_valid=1 two cycles later.
//   Output
//     - m_valid = (occ != 0); m_data = head entry, stable while m_valid && !m_ready.
//     - Pop on m_valid && m_ready.
//     - Capture and pop in the same cycle: occ unchanged; both pointers advance.
//     - Never overflow: the issue rule guarantees occ + inflight <= BUF_DEPTH.
//   Framing
//     - beat increments on each handshake; wraps to 0 after PKT_LEN-1.
//     - m_last = m_valid && (beat == PKT_LEN-1); PKT_LEN=1 -> m_last=1 on every valid beat.
//   Flags
//     - busy = (occ != 0) || inflight.
//   Reset mid-operation
//     - Buffered and in-flight words are discarded; framing restarts at beat 0.
//     - The FIFO shares this reset, so no stale pop survives.
//   Ordering
//     - Strict FIFO order; no word dropped or duplicated.
// TESTING
//   1 Reset: rst=0 with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0.
//   2 Latency: preload FIFO 0x11, m_ready=1
//       -> rd_en in cycle 0, m_valid=1 with m_data=0x11 in cycle 2, busy falls in cycle 3.
//   3 Throughput: FIFO holds 0x00..0x07, m_ready=1 constant
//       -> 8 consecutive handshakes, one per clk, in order.
//       -> m_last=1 on 0x03 and 0x07 only.
//   4 Backpressure: 6 words queued, m_ready=0 for 10 cycles
//       -> exactly BUF_DEPTH=3 pops, m_data holds 0x00.
//       -> releasing m_ready delivers 0x00..0x05 in order, no loss.
//   5 Simultaneous: occ=3, m_ready pulses 1 cycle with FIFO non-empty
//       -> one pop next cycle, occ returns to 3.
//       -> a random m_ready soak (1000 words) matches the scoreboard.
//   6 Reset mid-packet: reset after 2 beats of a packet
//       -> m_valid=0 and occ=0 immediately.
//       -> after refill, m_last first appears on the 4th beat.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-read-latency sync FIFO into a valid/ready stream with packet framing (m_last).
// Latency: FIFO non-empty -> m_valid two cycles later; sustains 1 word/clk when BUF_DEPTH >= 3.
// Backpressure: m_ready low fills the output buffer, then fifo_rd_en stops; fifo_rd_en never depends on m_ready.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic                  capture;
    logic                  pop;

    // Outputs and read issue: only registered state and fifo_empty, so m_ready never reaches fifo_rd_en.
    // Room is reserved for the word already in flight; reset blocks any pop.
    always_comb begin
        capture    = inflight_q;
        m_valid    = (occ_q != '0);
        pop        = m_valid && m_ready;
        fifo_rd_en = rst && !fifo_empty && ((int'(occ_q) + int'(inflight_q)) < BUF_DEPTH);
        m_data     = m_valid ? buf_q[head_q] : '0;
        m_last     = m_valid && (beat_q == BEAT_LAST);
        busy       = m_valid || inflight_q;
    end

    // Next-state: occupancy, circular pointers and beat counter.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        beat_d = beat_q;
        if (capture && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !capture) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (capture) begin
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    // Control state; reset discards buffered and in-flight words and restarts framing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
        end
    end

    // Data storage needs no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q[tail_q] <= fifo_rdata;
        end
    end
endmodule
